// File: rtl/ds2_pkg.sv
// Shared types and constants for the DualShock2 to C64 joystick mapper.
package ds2_pkg;

  // Port swap combo tracking
  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StLatched
  } swap_state_e;

  // Bit positions inside a {fire,right,left,down,up} joystick word
  localparam int unsigned UP    = 0;
  localparam int unsigned DOWN  = 1;
  localparam int unsigned LEFT  = 2;
  localparam int unsigned RIGHT = 3;
  localparam int unsigned FIRE  = 4;

  localparam logic [7:0] STICK_CENTRE = 8'h80;

endpackage

// File: rtl/ds2_joy_mapper_if.sv
// Controller-state inputs and C64 control-port outputs of ds2_joy_mapper.
// master: the side presenting decoded controller state; slave: the mapper.
interface ds2_joy_mapper_if;

  logic       analog;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       key_cross;
  logic       key_square;
  logic       key_circle;
  logic       key_select;
  logic       key_start;
  logic [7:0] stick_lx;
  logic [7:0] stick_ly;
  logic [7:0] stick_rx;
  logic [7:0] stick_ry;

  logic [4:0] joy1_n;
  logic [4:0] joy2_n;
  logic [7:0] pot_x;
  logic [7:0] pot_y;
  logic       swapped;

  modport master (
    output analog, key_up, key_down, key_left, key_right, key_cross, key_square,
           key_circle, key_select, key_start, stick_lx, stick_ly, stick_rx, stick_ry,
    input  joy1_n, joy2_n, pot_x, pot_y, swapped
  );

  modport slave (
    input  analog, key_up, key_down, key_left, key_right, key_cross, key_square,
           key_circle, key_select, key_start, stick_lx, stick_ly, stick_rx, stick_ry,
    output joy1_n, joy2_n, pot_x, pot_y, swapped
  );

endinterface

// File: rtl/ds2_axis_hyst.sv
// One stick axis to neg/pos direction bits with assert/release hysteresis.
// neg_o/pos_o present the state being loaded on this frame_tick, so the
// caller sees the direction for the current frame in the tick cycle itself.
module ds2_axis_hyst
  import ds2_pkg::*;
#(
  parameter logic [7:0] THR_ON  = 8'd64,
  parameter logic [7:0] THR_OFF = 8'd32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick_i,
  input  logic       analog_i,
  input  logic [7:0] pos_i,
  output logic       neg_o,
  output logic       pos_o
);

  localparam logic signed [8:0] ThrOnP  = $signed({1'b0, THR_ON});
  localparam logic signed [8:0] ThrOffP = $signed({1'b0, THR_OFF});
  localparam logic signed [8:0] ThrOnN  = -ThrOnP;
  localparam logic signed [8:0] ThrOffN = -ThrOffP;

  logic signed [8:0] diff;
  logic              neg_q, neg_d;
  logic              pos_q, pos_d;

  // Signed distance from centre, -128..127, no wrap
  assign diff = $signed({1'b0, pos_i}) - $signed({1'b0, STICK_CENTRE});

  // Hysteresis next state, evaluated only on frame ticks
  always_comb begin
    neg_d = neg_q;
    pos_d = pos_q;
    if (frame_tick_i) begin
      if (!analog_i) begin
        neg_d = 1'b0;
        pos_d = 1'b0;
      end else begin
        pos_d = (diff >= ThrOnP) || (pos_q && (diff >= ThrOffP));
        neg_d = (diff <= ThrOnN) || (neg_q && (diff <= ThrOffN));
        // Guard against both sides when THR_OFF is zero
        if (pos_d) neg_d = 1'b0;
      end
    end
  end

  // Hysteresis state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      pos_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
      pos_q <= pos_d;
    end
  end

  assign neg_o = neg_d;
  assign pos_o = pos_d;

endmodule

// File: rtl/ds2_joy_mapper.sv
// DualShock2 state to C64 control ports: two active-low joysticks plus a
// paddle pair, updated once per frame on the synchronised vsync rising edge.
// Optional autofire on key_square is built only when DS2_AUTOFIRE_EN is defined.
module ds2_joy_mapper
  import ds2_pkg::*;
#(
  parameter logic [7:0]  THR_ON          = 8'd64,
  parameter logic [7:0]  THR_OFF         = 8'd32,
  parameter int unsigned AUTOFIRE_FRAMES = 4,
  parameter int unsigned SWAP_FRAMES     = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  ds2_joy_mapper_if.slave   bus
);

  localparam logic [15:0] SwapLast = 16'(SWAP_FRAMES);

  logic [1:0]  sync_q, sync_d;
  logic        sync_prev_q, sync_prev_d;
  logic        tick_q, tick_d;

  logic        x_neg, x_pos, y_neg, y_pos;
  logic        af_fire;
  logic [4:0]  ctrl_n;

  swap_state_e state_q, state_d;
  logic [15:0] swap_cnt_q, swap_cnt_d;
  logic        swapped_q, swapped_d;
  logic        combo;

  logic [4:0]  joy1_q, joy1_d;
  logic [4:0]  joy2_q, joy2_d;
  logic [7:0]  pot_x_q, pot_x_d;
  logic [7:0]  pot_y_q, pot_y_d;

  // vsync synchroniser and registered rising-edge detector
  always_comb begin
    sync_d      = {sync_q[0], vsync};
    sync_prev_d = sync_q[1];
    tick_d      = sync_q[1] & ~sync_prev_q;
  end

  // Frame strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b00;
      sync_prev_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      tick_q      <= tick_d;
    end
  end

  ds2_axis_hyst #(
    .THR_ON  (THR_ON),
    .THR_OFF (THR_OFF)
  ) u_hyst_x (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick_i (tick_q),
    .analog_i     (bus.analog),
    .pos_i        (bus.stick_lx),
    .neg_o        (x_neg),
    .pos_o        (x_pos)
  );

  ds2_axis_hyst #(
    .THR_ON  (THR_ON),
    .THR_OFF (THR_OFF)
  ) u_hyst_y (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick_i (tick_q),
    .analog_i     (bus.analog),
    .pos_i        (bus.stick_ly),
    .neg_o        (y_neg),
    .pos_o        (y_pos)
  );

`ifdef DS2_AUTOFIRE_EN
  localparam logic [3:0] AfLast = 4'(AUTOFIRE_FRAMES - 1);

  logic [3:0] af_cnt_q, af_cnt_d;
  logic       af_ph_q, af_ph_d;
  logic       af_on_q, af_on_d;

  // Autofire counter/phase; a fresh press starts in the firing phase
  always_comb begin
    af_cnt_d = af_cnt_q;
    af_ph_d  = af_ph_q;
    af_on_d  = af_on_q;
    if (tick_q) begin
      if (!bus.key_square) begin
        af_cnt_d = 4'd0;
        af_ph_d  = 1'b0;
        af_on_d  = 1'b0;
      end else if (!af_on_q) begin
        af_cnt_d = 4'd0;
        af_ph_d  = 1'b1;
        af_on_d  = 1'b1;
      end else if (af_cnt_q == AfLast) begin
        af_cnt_d = 4'd0;
        af_ph_d  = ~af_ph_q;
      end else begin
        af_cnt_d = af_cnt_q + 4'd1;
      end
    end
    af_fire = af_ph_d;
  end

  // Autofire state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_cnt_q <= 4'd0;
      af_ph_q  <= 1'b0;
      af_on_q  <= 1'b0;
    end else begin
      af_cnt_q <= af_cnt_d;
      af_ph_q  <= af_ph_d;
      af_on_q  <= af_on_d;
    end
  end
`else
  logic       unused_square;
  logic [3:0] unused_af_frames;

  assign af_fire          = 1'b0;
  assign unused_square    = bus.key_square;
  assign unused_af_frames = AUTOFIRE_FRAMES[3:0];
`endif

  // Controller joystick word, active-low
  always_comb begin
    ctrl_n        = 5'h1F;
    ctrl_n[UP]    = ~(bus.key_up    | (bus.analog & y_neg));
    ctrl_n[DOWN]  = ~(bus.key_down  | (bus.analog & y_pos));
    ctrl_n[LEFT]  = ~(bus.key_left  | (bus.analog & x_neg));
    ctrl_n[RIGHT] = ~(bus.key_right | (bus.analog & x_pos));
    ctrl_n[FIRE]  = ~(bus.key_cross | af_fire);
  end

  assign combo = bus.key_select & bus.key_start;

  // Swap FSM: one toggle per continuous hold of select+start
  always_comb begin
    state_d    = state_q;
    swap_cnt_d = swap_cnt_q;
    swapped_d  = swapped_q;
    if (tick_q) begin
      unique case (state_q)
        StIdle: begin
          if (combo) begin
            swap_cnt_d = 16'd1;
            if (SwapLast <= 16'd1) begin
              swapped_d = ~swapped_q;
              state_d   = StLatched;
            end else begin
              state_d = StArmed;
            end
          end
        end
        StArmed: begin
          if (!combo) begin
            swap_cnt_d = 16'd0;
            state_d    = StIdle;
          end else begin
            swap_cnt_d = swap_cnt_q + 16'd1;
            if (swap_cnt_d >= SwapLast) begin
              swapped_d = ~swapped_q;
              state_d   = StLatched;
            end
          end
        end
        StLatched: begin
          if (!combo) begin
            swap_cnt_d = 16'd0;
            state_d    = StIdle;
          end
        end
        default: begin
          swap_cnt_d = 16'd0;
          state_d    = StIdle;
        end
      endcase
    end
  end

  // Output next state: routing follows the swap state loaded this frame
  always_comb begin
    joy1_d  = joy1_q;
    joy2_d  = joy2_q;
    pot_x_d = pot_x_q;
    pot_y_d = pot_y_q;
    if (tick_q) begin
      joy1_d  = swapped_d ? ctrl_n : 5'h1F;
      joy2_d  = swapped_d ? 5'h1F : ctrl_n;
      pot_x_d = bus.key_circle ? 8'hFF : (bus.analog ? bus.stick_rx : STICK_CENTRE);
      pot_y_d = bus.analog ? bus.stick_ry : STICK_CENTRE;
    end
  end

  // Swap FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      swap_cnt_q <= 16'd0;
      swapped_q  <= 1'b0;
      joy1_q     <= 5'h1F;
      joy2_q     <= 5'h1F;
      pot_x_q    <= STICK_CENTRE;
      pot_y_q    <= STICK_CENTRE;
    end else begin
      state_q    <= state_d;
      swap_cnt_q <= swap_cnt_d;
      swapped_q  <= swapped_d;
      joy1_q     <= joy1_d;
      joy2_q     <= joy2_d;
      pot_x_q    <= pot_x_d;
      pot_y_q    <= pot_y_d;
    end
  end

  assign bus.joy1_n  = joy1_q;
  assign bus.joy2_n  = joy2_q;
  assign bus.pot_x   = pot_x_q;
  assign bus.pot_y   = pot_y_q;
  assign bus.swapped = swapped_q;

endmodule

// File: doc/ds2_joy_mapper.md
# ds2_joy_mapper

Frame-synchronous mapper that sits directly downstream of the `dualshock2` controller interface. It converts the decoded DualShock2 button and stick state into C64 control-port signals: two active-low digital joysticks plus one 8-bit paddle pair. Outputs update once per video frame on `vsync`. The block provides analog-stick-to-direction conversion with hysteresis, frame-counted autofire, and a held-combo joystick port swap.

## Interface
- `THR_ON`, default 8'd64: distance from centre 0x80 at which a stick direction asserts.
- `THR_OFF`, default 8'd32: distance from centre below which an asserted stick direction releases. `THR_OFF` < `THR_ON` is required.
- `AUTOFIRE_FRAMES`, default 4: frames per autofire half-period, range 1..15.
- `SWAP_FRAMES`, default 60: frames the swap combo must be held.
- `clk`  input  1  system clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `vsync`  input  1  frame strobe, level, treated as asynchronous.
- `analog`  input  1  stick mode; 1 = sticks drive directions.
- `key_up`, `key_down`, `key_left`, `key_right`, `key_cross`, `key_square`, `key_circle`, `key_select`, `key_start`  input  1 each  DS2 buttons, 1 = pressed.
- `stick_lx`, `stick_ly`, `stick_rx`, `stick_ry`  input  8 each  stick positions; 0x00 = left/up, 0xFF = right/down.
- `joy1_n`  output  5  port 1 {fire,right,left,down,up}, active-low.
- `joy2_n`  output  5  port 2, same encoding.
- `pot_x`, `pot_y`  output  8 each  paddle values.
- `swapped`  output  1  1 = controller drives port 1.

## Operation
- `vsync` passes through a 2-flop synchroniser. `frame_tick` is a one-cycle pulse on the synchronised rising edge. All outputs and frame counters change only on `frame_tick`.
- Stick direction, per axis and per side, uses the left stick only. Right asserts when `stick_lx` >= 0x80+`THR_ON`. It releases when `stick_lx` < 0x80+`THR_OFF`. The left, up and down directions are mirror-symmetric. Compare using 9-bit signed `stick`−0x80; there is no wrap-around. Opposite directions can never both be set. Hysteresis state clears while `analog`=0.
- Direction = d-pad OR stick direction (stick only when `analog`=1).
- Fire = `key_cross` OR autofire output.
- Autofire:
  - While `key_square` is held, a 4-bit frame counter counts to `AUTOFIRE_FRAMES`−1, then wraps and toggles the autofire phase. The first press starts with phase=1 (fire asserted on the first frame).
  - On release, the counter and phase clear at the next `frame_tick`.
- Swap FSM, advanced on `frame_tick`:
  - IDLE: combo (`key_select`&`key_start`) → ARMED, counter=1.
  - ARMED: combo released → IDLE. Counter reaching `SWAP_FRAMES` → toggle `swapped`, go to LATCHED.
  - LATCHED: combo released → IDLE.
  - One toggle happens per hold.
- Port routing:
  - With `swapped`=0, the controller drives `joy2_n` and `joy1_n`=5'h1F.
  - With `swapped`=1, the routing is reversed.
- `pot_x`=`stick_rx`, `pot_y`=`stick_ry` while `analog`=1; otherwise both are 8'h80.
- `key_circle` forces `pot_x`=8'hFF (paddle button emulation) regardless of `analog`.

## Timing
- If `vsync` is first sampled high at edge N, `frame_tick` is high during the cycle after edge N+2. Outputs change at edge N+3.
- Inputs are sampled in the `frame_tick` cycle only; changes between ticks are invisible.
- Reset values:
  - `joy1_n`=`joy2_n`=5'h1F, `pot_x`=`pot_y`=8'h80, `swapped`=0.
  - FSM=IDLE, counters=0, hysteresis cleared, synchroniser=0.
- When `rst_n` is asserted mid-frame or mid-swap-hold, all state returns to reset values immediately. There is no swap toggle. The first `frame_tick` after release needs a fresh `vsync` rising edge.
- `vsync` held high gives no further ticks.

## Configuration
- `DS2_AUTOFIRE_EN` defined: autofire logic is as described.
- `DS2_AUTOFIRE_EN` undefined: autofire counter and phase are removed, `key_square` is ignored, and fire = `key_cross` only. `AUTOFIRE_FRAMES` is accepted but unused.

## Structure
- The shared package `ds2_pkg` holds:
  - the swap state enum (IDLE, ARMED, LATCHED);
  - the joystick bit-index constants (UP=0 … FIRE=4);
  - `STICK_CENTRE`=8'h80.
- One sub-module, `ds2_axis_hyst`, is instantiated twice (X and Y). It takes an 8-bit position, `analog`, `frame_tick` and the thresholds, and outputs neg/pos direction bits with hysteresis state.

## Test plan
- Reset, then `key_up`=1 and a `vsync` pulse → `joy2_n`=5'h1E exactly 3 edges after `vsync` is sampled; `joy1_n`=5'h1F.
- `analog`=1, `stick_lx` sweep 0x80→0xC0→0xA8→0x9F over successive frames → right bit asserted at 0xC0, still asserted at 0xA8, released at 0x9F.
- `key_square` held 16 frames with `AUTOFIRE_FRAMES`=4 → fire bit pattern 0,0,0,0 then 1,1,1,1 repeating (active-low).
- Select+start held 70 frames → `swapped` toggles at frame 60 only. Release and hold again 60 frames → toggles back. Joystick traffic moves to `joy1_n`.
- Combo held 30 frames, `rst_n` pulsed low, then held 40 more frames → `swapped`=0.
- Build without `DS2_AUTOFIRE_EN`, `key_square` held → fire stays 1. `key_circle` → `pot_x`=8'hFF; `analog`=0 → `pot_y`=8'h80.
